// File: rtl/sram_pixel_arbiter.sv
// Shares one 16-bit frame SRAM between display (read-only, priority) and painter (read/write).
// Each pixel is stored as a two-word pair; a granted access always runs two SRAM cycles.
module sram_pixel_arbiter #(
    parameter int IDX_W           = 19,
    parameter int MAX_DISP_STREAK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_disp_req,
    input  logic [IDX_W-1:0] i_disp_idx,
    output logic             o_disp_gnt,
    output logic             o_disp_valid,
    output logic [23:0]      o_disp_pixel,
    input  logic             i_pnt_req,
    input  logic             i_pnt_we,
    input  logic [IDX_W-1:0] i_pnt_idx,
    input  logic [23:0]      i_pnt_wdata,
    output logic             o_pnt_gnt,
    output logic             o_pnt_rvalid,
    output logic [23:0]      o_pnt_rdata,
    output logic [IDX_W:0]   o_sram_addr,
    output logic [15:0]      o_sram_wdata,
    output logic             o_sram_dq_oe,
    input  logic [15:0]      i_sram_rdata,
    output logic             o_sram_ce_n,
    output logic             o_sram_oe_n,
    output logic             o_sram_we_n,
    output logic             o_sram_lb_n,
    output logic             o_sram_ub_n
);

    typedef enum logic [2:0] {IDLE, RD_W0, RD_W1, WR_W0, WR_W1} state_t;

    localparam int STREAK_W = $clog2(MAX_DISP_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DISP_STREAK);

    state_t              state;
    logic [IDX_W-1:0]    idx_q;
    logic                owner_pnt_q;
    logic [15:0]         wdata_w1_q;
    logic [12:0]         w0_q;
    logic [STREAK_W-1:0] streak;

    logic        idle, pnt_wins, disp_gnt, pnt_gnt;
    logic [23:0] rd_pixel;
    logic        unused_rdata;

    function automatic logic [15:0] pack_w0(input logic [23:0] p);
        return {1'b0, p[15:11], p[23:16], 2'b00};
    endfunction

    function automatic logic [15:0] pack_w1(input logic [23:0] p);
        return {1'b0, p[10:8], 2'b00, p[7:0], 2'b00};
    endfunction

    assign idle     = (state == IDLE);
    assign pnt_wins = i_pnt_req && (!i_disp_req || streak == STREAK_MAX);
    assign disp_gnt = idle && i_disp_req && !pnt_wins;
    assign pnt_gnt  = idle && pnt_wins;

    assign o_disp_gnt = disp_gnt;
    assign o_pnt_gnt  = pnt_gnt;

    // w0_q keeps {w0[14:10], w0[9:2]}; the word pair only carries 24 useful bits
    assign rd_pixel     = {w0_q[7:0], w0_q[12:8], i_sram_rdata[14:12], i_sram_rdata[9:2]};
    assign unused_rdata = ^{i_sram_rdata[15], i_sram_rdata[11:10], i_sram_rdata[1:0]};

    // Strobes come straight from the state register so reset releases the bus at once
    assign o_sram_ce_n  = idle;
    assign o_sram_lb_n  = idle;
    assign o_sram_ub_n  = idle;
    assign o_sram_oe_n  = !(state == RD_W0 || state == RD_W1);
    assign o_sram_we_n  = !(state == WR_W0 || state == WR_W1);
    assign o_sram_dq_oe = (state == WR_W0 || state == WR_W1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            idx_q        <= '0;
            owner_pnt_q  <= 1'b0;
            wdata_w1_q   <= '0;
            w0_q         <= '0;
            streak       <= '0;
            o_sram_addr  <= '0;
            o_sram_wdata <= '0;
            o_disp_valid <= 1'b0;
            o_disp_pixel <= '0;
            o_pnt_rvalid <= 1'b0;
            o_pnt_rdata  <= '0;
        end else begin
            o_disp_valid <= 1'b0;
            o_pnt_rvalid <= 1'b0;

            if (pnt_gnt)
                streak <= '0;
            else if (disp_gnt && i_pnt_req)
                streak <= (streak == STREAK_MAX) ? streak : streak + STREAK_W'(1);
            else if (idle && !i_pnt_req)
                streak <= '0;

            case (state)
                IDLE: begin
                    if (disp_gnt) begin
                        idx_q       <= i_disp_idx;
                        owner_pnt_q <= 1'b0;
                        o_sram_addr <= {i_disp_idx, 1'b0};
                        state       <= RD_W0;
                    end else if (pnt_gnt) begin
                        idx_q       <= i_pnt_idx;
                        owner_pnt_q <= 1'b1;
                        o_sram_addr <= {i_pnt_idx, 1'b0};
                        if (i_pnt_we) begin
                            o_sram_wdata <= pack_w0(i_pnt_wdata);
                            wdata_w1_q   <= pack_w1(i_pnt_wdata);
                            state        <= WR_W0;
                        end else begin
                            state <= RD_W0;
                        end
                    end
                end
                RD_W0: begin
                    w0_q        <= {i_sram_rdata[14:10], i_sram_rdata[9:2]};
                    o_sram_addr <= {idx_q, 1'b1};
                    state       <= RD_W1;
                end
                RD_W1: begin
                    if (owner_pnt_q) begin
                        o_pnt_rdata  <= rd_pixel;
                        o_pnt_rvalid <= 1'b1;
                    end else begin
                        o_disp_pixel <= rd_pixel;
                        o_disp_valid <= 1'b1;
                    end
                    state <= IDLE;
                end
                WR_W0: begin
                    o_sram_addr  <= {idx_q, 1'b1};
                    o_sram_wdata <= wdata_w1_q;
                    state        <= WR_W1;
                end
                WR_W1: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_pixel_arbiter.sv
// Directed bench for sram_pixel_arbiter with a small behavioural SRAM.
module tb_sram_pixel_arbiter;
    localparam int IDX_W = 19;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             disp_req, pnt_req, pnt_we;
    logic [IDX_W-1:0] disp_idx, pnt_idx;
    logic [23:0]      pnt_wdata;
    logic             disp_gnt, disp_valid, pnt_gnt, pnt_rvalid;
    logic [23:0]      disp_pixel, pnt_rdata;
    logic [IDX_W:0]   sram_addr;
    logic [15:0]      sram_wdata, sram_rdata;
    logic             dq_oe, ce_n, oe_n, we_n, lb_n, ub_n;

    logic [15:0] mem [0:63];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_pixel_arbiter #(.IDX_W(IDX_W), .MAX_DISP_STREAK(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_disp_req(disp_req), .i_disp_idx(disp_idx), .o_disp_gnt(disp_gnt),
        .o_disp_valid(disp_valid), .o_disp_pixel(disp_pixel),
        .i_pnt_req(pnt_req), .i_pnt_we(pnt_we), .i_pnt_idx(pnt_idx),
        .i_pnt_wdata(pnt_wdata), .o_pnt_gnt(pnt_gnt), .o_pnt_rvalid(pnt_rvalid),
        .o_pnt_rdata(pnt_rdata), .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata),
        .o_sram_dq_oe(dq_oe), .i_sram_rdata(sram_rdata), .o_sram_ce_n(ce_n),
        .o_sram_oe_n(oe_n), .o_sram_we_n(we_n), .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
    );

    assign sram_rdata = (!ce_n && !oe_n) ? mem[sram_addr[5:0]] : 16'h0000;

    always @(negedge clk)
        if (rst_n && !ce_n && !we_n && dq_oe)
            mem[sram_addr[5:0]] <= sram_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ng;
        int last;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[10] = 16'h1848;
        mem[11] = 16'h4158;
        rst_n = 1'b0; disp_req = 1'b0; pnt_req = 1'b0; pnt_we = 1'b0;
        disp_idx = '0; pnt_idx = '0; pnt_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ce_n", ce_n, 1);
        chk("rst_ctl", {oe_n, we_n, lb_n, ub_n, dq_oe}, 5'b11110);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_valid", {disp_valid, pnt_rvalid, disp_gnt, pnt_gnt}, 0);
        chk("rst_pix", {disp_pixel, pnt_rdata}, 0);
        rst_n = 1'b1;
        tick();

        // Display read idx 5
        disp_req = 1'b1; disp_idx = 5;
        #1 chk("d1_gnt", {disp_gnt, pnt_gnt}, 2'b10);
        tick(); disp_req = 1'b0;
        chk("d1_addr0", sram_addr, 10);
        chk("d1_ctl0", {ce_n, oe_n, we_n, dq_oe}, 4'b0010);
        tick();
        chk("d1_addr1", sram_addr, 11);
        chk("d1_ctl1", {ce_n, oe_n, we_n, dq_oe}, 4'b0010);
        tick();
        chk("d1_valid", {disp_valid, pnt_rvalid}, 2'b10);
        chk("d1_pixel", disp_pixel, 24'h123456);
        chk("d1_idle", ce_n, 1);
        tick();
        chk("d1_pulse", disp_valid, 0);

        // Painter write idx 7
        pnt_req = 1'b1; pnt_we = 1'b1; pnt_idx = 7; pnt_wdata = 24'h123456;
        #1 chk("w1_gnt", {disp_gnt, pnt_gnt}, 2'b01);
        tick(); pnt_req = 1'b0;
        chk("w1_ctl0", {ce_n, oe_n, we_n, dq_oe}, 4'b0101);
        chk("w1_a0", {sram_addr, sram_wdata}, {20'd14, 16'h1848});
        tick();
        chk("w1_ctl1", {ce_n, oe_n, we_n, dq_oe}, 4'b0101);
        chk("w1_a1", {sram_addr, sram_wdata}, {20'd15, 16'h4158});
        tick();
        chk("w1_end", {we_n, dq_oe, disp_valid, pnt_rvalid}, 4'b1000);
        chk("w1_mem", {mem[14], mem[15]}, 32'h1848_4158);

        // Painter read-back idx 7
        pnt_req = 1'b1; pnt_we = 1'b0;
        #1 chk("r1_gnt", pnt_gnt, 1);
        tick(); pnt_req = 1'b0;
        chk("r1_oe", {oe_n, we_n}, 2'b01);
        tick(); tick();
        chk("r1_valid", {disp_valid, pnt_rvalid}, 2'b01);
        chk("r1_rdata", pnt_rdata, 24'h123456);

        // Write all-ones pixel to idx 8, then read it back
        pnt_req = 1'b1; pnt_we = 1'b1; pnt_idx = 8; pnt_wdata = 24'hFFFFFF;
        #1 chk("w2_gnt", pnt_gnt, 1);
        tick(); pnt_req = 1'b0;
        chk("w2_w0", {sram_addr, sram_wdata}, {20'd16, 16'h7FFC});
        tick();
        chk("w2_w1", {sram_addr, sram_wdata}, {20'd17, 16'h73FC});
        tick();
        pnt_req = 1'b1; pnt_we = 1'b0;
        #1 chk("r2_gnt", pnt_gnt, 1);
        tick(); pnt_req = 1'b0;
        tick(); tick();
        chk("r2_rdata", {pnt_rvalid, pnt_rdata}, {1'b1, 24'hFFFFFF});
        chk("r2_hold", disp_pixel, 24'h123456);

        // Both requesting continuously
        disp_req = 1'b1; disp_idx = 1; pnt_req = 1'b1; pnt_we = 1'b0; pnt_idx = 2;
        ng = 0; last = -3;
        for (int c = 0; c < 40 && ng < 10; c++) begin
            #1;
            chk("arb_excl", disp_gnt & pnt_gnt, 0);
            if (disp_gnt || pnt_gnt) begin
                chk("arb_who", pnt_gnt, (ng % 5 == 4) ? 1 : 0);
                chk("arb_gap", c - last, 3);
                last = c;
                ng++;
            end
            tick();
        end
        chk("arb_count", ng, 10);
        disp_req = 1'b0; pnt_req = 1'b0;
        tick(); tick(); tick();

        // Simultaneous first request
        disp_req = 1'b1; disp_idx = 5; pnt_req = 1'b1; pnt_we = 1'b0; pnt_idx = 7;
        #1 chk("s_gnt0", {disp_gnt, pnt_gnt}, 2'b10);
        tick();
        chk("s_busy", pnt_gnt, 0);
        tick(); tick();
        chk("s_gnt1", {disp_gnt, pnt_gnt}, 2'b10);
        chk("s_pix", {disp_valid, disp_pixel}, {1'b1, 24'h123456});
        tick(); disp_req = 1'b0;
        tick(); tick();
        chk("s_gnt2", {disp_gnt, pnt_gnt}, 2'b01);
        tick(); pnt_req = 1'b0;
        tick(); tick();
        chk("s_rd", {pnt_rvalid, pnt_rdata}, {1'b1, 24'h123456});

        // Reset during RD_W1
        disp_req = 1'b1; disp_idx = 5;
        #1 chk("x_gnt", disp_gnt, 1);
        tick(); disp_req = 1'b0;
        tick();
        chk("x_rdw1", {ce_n, oe_n, sram_addr}, {2'b00, 20'd11});
        rst_n = 1'b0;
        #1 chk("x_abort", {ce_n, oe_n, we_n, lb_n, ub_n, dq_oe}, 6'b111110);
        tick();
        chk("x_novalid", {disp_valid, pnt_rvalid, disp_pixel}, 0);
        rst_n = 1'b1;
        tick();
        chk("x_novalid2", disp_valid, 0);
        disp_req = 1'b1;
        #1 chk("x_gnt2", disp_gnt, 1);
        tick(); disp_req = 1'b0;
        tick(); tick();
        chk("x_pix", {disp_valid, disp_pixel}, {1'b1, 24'h123456});

        // Reset during WR_W0
        pnt_req = 1'b1; pnt_we = 1'b1; pnt_idx = 9; pnt_wdata = 24'hABCDEF;
        #1 chk("y_gnt", pnt_gnt, 1);
        tick(); pnt_req = 1'b0;
        chk("y_we", we_n, 0);
        rst_n = 1'b0;
        #1 chk("y_abort", {we_n, dq_oe, ce_n}, 3'b101);
        tick(); rst_n = 1'b1;
        tick();
        chk("y_mem", {mem[18], mem[19]}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
